fetch_queue: RTL and testbench

//  Instruction prefetch buffer between instruction memory and the IF/ID stage register.

---
 rtl/fetch_queue_pkg.sv | 29 ++
 rtl/fetch_queue_sync_fifo.sv | 87 ++++++++
 rtl/fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_fetch_queue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared CPU constants and types used by the instruction prefetch buffer.
//   INSTR_W / PC_W   : instruction word and program counter widths
//   PC_STEP          : byte distance between sequential instructions
//   RESET_PC_DEFAULT : default fetch address after reset
//   fq_entry_t       : one buffered {instr, pc} pair, instr in the upper half
//   pc_advance()     : next sequential fetch address (wraps modulo 2^PC_W)
// ----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fq_entry_t;

    localparam int ENTRY_W = $bits(fq_entry_t);

    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] cur);
        return cur + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered storage and a synchronous clear.
//   The read port shows the head entry combinationally from storage, so a
//   word written this cycle is visible at the head no earlier than next cycle.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   push   in   write wdata at the tail (ignored when full)
//   pop    in   advance the head (ignored when empty)
//   clear  in   empty the FIFO; wins over push and pop
//   wdata  in   WIDTH-bit write data
//   rdata  out  WIDTH-bit head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  number of entries held, clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module sync_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Storage is never reset: an entry is only read once the count says it
    // has been written, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The occupancy
    // counter is kept separately so full and empty need no extra pointer bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch buffer between instruction memory and the IF/ID
//   stage register. Issues sequential fetches over an in-order,
//   variable-latency request/grant/rvalid handshake, buffers up to DEPTH
//   {instr, pc} pairs and presents the head entry to decode. A taken branch
//   flushes the buffer, redirects fetch and discards in-flight stale data.
// Parameters
//   DEPTH     queue entries (power of two, >= 2); also the fetch credit limit
//   RESET_PC  fetch address after reset
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   keep         in   decode stalled, head entry is not consumed
//   jump         in   taken branch: flush and redirect to target
//   target       in   redirect address
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (word aligned)
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   read data returned in request order
//   imem_rdata   in   returned instruction word
//   valid        out  head entry present
//   instr        out  head instruction (0 when no entry)
//   pc           out  head instruction address (0 when no entry)
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               keep,
    input  logic               jump,
    input  logic [PC_W-1:0]    target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fq_entry_t       fifo_wdata;
    fq_entry_t       fifo_head;

    logic [CW:0]     credit_used;
    logic            fire;
    logic            resp;
    logic            resp_keep;
    logic            head_pop;
    logic [CW-1:0]   resp_dec;

    // Issue credit covers both buffered entries and fetches still in flight,
    // so every accepted request is guaranteed a free slot when it returns.
    // The request is suppressed during a redirect and while reset is held.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
        imem_req    = rst && !jump && (credit_used < CREDIT_LIMIT);
        imem_addr   = fetch_pc;
        fire        = imem_req && imem_gnt;
    end

    // A response with nothing outstanding is a protocol violation and is
    // ignored. Responses still owed to a flushed stream are swallowed while
    // drop is non-zero, and any response arriving alongside a jump is stale.
    always_comb begin
        resp      = imem_rvalid && (outstanding != '0);
        resp_keep = resp && (drop == '0) && !jump && !fifo_full;
        resp_dec  = {{(CW-1){1'b0}}, resp};
        head_pop  = valid && !keep && !jump;
    end

    // Head presentation. instr and pc are forced to zero when the buffer is
    // empty so the IF/ID register sees a clean bubble.
    always_comb begin
        valid            = !fifo_empty;
        instr            = valid ? fifo_head.instr : '0;
        pc               = valid ? fifo_head.pc    : '0;
        fifo_wdata.instr = imem_rdata;
        fifo_wdata.pc    = resp_pc;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (resp_keep),
        .pop   (head_pop),
        .clear (jump),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Fetch address: steps by one word per accepted request and jumps to the
    // branch target on redirect. A request left ungranted simply holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (jump) begin
            fetch_pc <= target;
        end else if (fire) begin
            fetch_pc <= pc_advance(fetch_pc);
        end
    end

    // Response address: tags each kept response with the address it was
    // fetched from. Memory answers in order, so a second counter that only
    // advances on kept data tracks fetch_pc one round trip behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_pc <= RESET_PC;
        end else if (jump) begin
            resp_pc <= target;
        end else if (resp_keep) begin
            resp_pc <= pc_advance(resp_pc);
        end
    end

    // In-flight counter. A jump never issues, so on a redirect it can only
    // go down by the response that arrives in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({fire, resp})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Stale-response counter. On a redirect every fetch still in flight
    // belongs to the old stream, except a response consumed this very cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop <= '0;
        end else if (jump) begin
            drop <= outstanding - resp_dec;
        end else if (resp && (drop != '0)) begin
            drop <= drop - 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue. An in-order memory responder and a
//   queue-based reference model live in the bench; a compare process checks
//   every DUT output against the model each cycle, and directed scenarios
//   pin the model with hand-computed literal values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        keep;
    logic        jump;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;

    int n_tests;
    int n_fail;
    int cyc;

    logic [31:0] mq_pc[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_resp_pc;
    int          m_out;
    int          m_drop;
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];

    int rv_mode;
    int gnt_mode;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keep        (keep),
        .jump        (jump),
        .target      (target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid       (valid),
        .instr       (instr),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_1234) * 32'h0001_0003 + 32'h0000_0007;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge. The memory responder
    // returns the oldest granted fetch, never in the same cycle as its grant.
    task automatic applyStimulus(input bit k, input bit j, input logic [31:0] t);
        @(negedge clk);
        keep     = k;
        jump     = j;
        target   = t;
        imem_gnt = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
        if (rst && pend_addr.size() != 0 && pend_cyc[0] < cyc &&
            (rv_mode == 1 || (rv_mode == 2 && $urandom_range(0, 2) != 0))) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    // Pulls reset low between clock edges and checks the outputs drop at once.
    task automatic resetDut();
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_pc", pc, 32'd0);
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        keep        = 1'b0;
        jump        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitValid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            #1;
            if (valid) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s: valid never rose within 20 cycles", name);
        end
    endtask

    // Reference model: buffered pcs as a queue, fetch and response addresses,
    // in-flight and stale counts, plus the memory's pending-request list.
    always @(posedge clk or negedge rst) begin : model_update
        bit exp_req;
        bit fire;
        bit resp;
        if (!rst) begin
            mq_pc.delete();
            pend_addr.delete();
            pend_cyc.delete();
            m_fetch_pc = RESET_PC;
            m_resp_pc  = RESET_PC;
            m_out      = 0;
            m_drop     = 0;
        end else begin
            exp_req = !jump && (mq_pc.size() + m_out < DEPTH);
            fire    = exp_req && imem_gnt;
            if (imem_rvalid) begin
                checkOutput("rvalid_has_credit", 32'(m_out > 0), 32'd1);
            end
            resp = imem_rvalid && (m_out > 0);
            if (resp) begin
                void'(pend_addr.pop_front());
                void'(pend_cyc.pop_front());
            end
            if (jump) begin
                mq_pc.delete();
                m_drop     = m_out - (resp ? 1 : 0);
                m_out      = m_out - (resp ? 1 : 0);
                m_fetch_pc = target;
                m_resp_pc  = target;
            end else begin
                if (mq_pc.size() != 0 && !keep) begin
                    void'(mq_pc.pop_front());
                end
                if (resp) begin
                    m_out--;
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        mq_pc.push_back(m_resp_pc);
                        m_resp_pc = m_resp_pc + 32'd4;
                    end
                end
                if (fire) begin
                    pend_addr.push_back(m_fetch_pc);
                    pend_cyc.push_back(cyc);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                    m_out++;
                end
            end
            cyc++;
        end
    end

    // Every-cycle comparison, sampled after the falling-edge stimulus settles.
    always @(negedge clk) begin : compare_outputs
        bit exp_req;
        #2;
        exp_req = rst && !jump && (mq_pc.size() + m_out < DEPTH);
        checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
        checkOutput("imem_addr", imem_addr, m_fetch_pc);
        checkOutput("valid", 32'(valid), 32'(mq_pc.size() != 0));
        if (mq_pc.size() != 0) begin
            checkOutput("pc", pc, mq_pc[0]);
            checkOutput("instr", instr, mem_word(mq_pc[0]));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit          ok;
        logic [31:0] rnd_target;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        rv_mode     = 1;
        gnt_mode    = 1;
        keep        = 1'b0;
        jump        = 1'b0;
        target      = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        rst         = 1'b1;
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("init_valid", 32'(valid), 32'd0);
        checkOutput("init_req", 32'(imem_req), 32'd0);
        checkOutput("init_addr", imem_addr, RESET_PC);
        checkOutput("init_instr", instr, 32'd0);
        checkOutput("init_pc", pc, 32'd0);
        imem_gnt = 1'b1;
        rst      = 1'b1;

        $display("[TB] scenario 1: streaming fetch");
        applyStimulus(1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("t1_valid_early", 32'(valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            #1;
            checkOutput("t1_valid", 32'(valid), 32'd1);
            checkOutput("t1_pc", pc, 32'(4 * i));
            checkOutput("t1_instr", instr, mem_word(32'(4 * i)));
        end

        $display("[TB] scenario 2: decode stall fills the queue");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0);
        #1;
        checkOutput("t2_req_full", 32'(imem_req), 32'd0);
        checkOutput("t2_head_pc", pc, 32'h20);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            #1;
            checkOutput("t2_drain_pc", pc, 32'(32'h20 + 4 * i));
        end

        $display("[TB] scenario 3: jump with two fetches in flight");
        resetDut();
        rv_mode = 0;
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        rv_mode = 1;
        waitValid("t3_wait", ok);
        if (ok) begin
            checkOutput("t3_pc", pc, 32'h100);
            checkOutput("t3_instr", instr, mem_word(32'h100));
        end

        $display("[TB] scenario 4: jump coincident with a response");
        resetDut();
        rv_mode = 0;
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        rv_mode = 1;
        applyStimulus(1'b0, 1'b1, 32'h200);
        #1;
        checkOutput("t4_rvalid_with_jump", 32'(imem_rvalid), 32'd1);
        waitValid("t4_wait", ok);
        if (ok) begin
            checkOutput("t4_pc", pc, 32'h200);
            checkOutput("t4_instr", instr, mem_word(32'h200));
        end

        $display("[TB] scenario 5: grant withheld");
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        gnt_mode = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            #1;
            checkOutput("t5_addr_hold", imem_addr, 32'h8);
            checkOutput("t5_req_hold", 32'(imem_req), 32'd1);
        end
        gnt_mode = 1;
        applyStimulus(1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("t5_addr_at_grant", imem_addr, 32'h8);
        applyStimulus(1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("t5_addr_after", imem_addr, 32'hC);

        $display("[TB] scenario 6: asynchronous reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        resetDut();
        applyStimulus(1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("t6_first_addr", imem_addr, RESET_PC);
        waitValid("t6_wait", ok);
        if (ok) begin
            checkOutput("t6_pc", pc, RESET_PC);
            checkOutput("t6_instr", instr, mem_word(RESET_PC));
        end

        $display("[TB] random phase");
        gnt_mode = 2;
        rv_mode  = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) resetDut();
            rnd_target       = $urandom;
            rnd_target[1:0]  = 2'b00;
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rnd_target);
        end
        applyStimulus(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
